register_file: RTL and testbench

- Architectural register file with per-register rename tags.
- Sits downstream of the reorder buffer and consumes its commit stream (rf_valid/rf_index/rf_rd/rf_value) and its flush.
- Also serves the issue unit:
  - records which ROB entry will produce each register;
  - answers operand lookups as either a value or a pending ROB tag.

---
 rtl/register_file_pkg.sv | 11 +
 rtl/register_file_rf_read_port.sv | 42 ++++
 rtl/register_file.sv | 101 ++++++++++
 tb/tb_register_file.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/register_file_pkg.sv
// Shared configuration for the architectural register file.
package register_file_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned REG_NUM   = 32;
    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned ROB_IDX_W = 6;

    localparam logic [REG_IDX_W-1:0] ZERO_REG = REG_IDX_W'(0);

endpackage

// File: rtl/register_file_rf_read_port.sv
// Single combinational operand lookup with x0 masking.
// Optional macro RF_COMMIT_BYPASS_EN forwards a same-cycle commit that
// retires the register's current producer.
module rf_read_port
    import register_file_pkg::*;
(
    input  logic [REG_IDX_W-1:0]                rs_addr,
    input  logic [REG_NUM-1:0][XLEN-1:0]        reg_value,
    input  logic [REG_NUM-1:0]                  reg_busy,
    input  logic [REG_NUM-1:0][ROB_IDX_W-1:0]   reg_tag,
`ifdef RF_COMMIT_BYPASS_EN
    input  logic                                rdy,
    input  logic                                rf_valid,
    input  logic [ROB_IDX_W-1:0]                rf_index,
    input  logic [REG_IDX_W-1:0]                rf_rd,
    input  logic [XLEN-1:0]                     rf_value,
`endif
    output logic [XLEN-1:0]                     rs_value,
    output logic                                rs_busy,
    output logic [ROB_IDX_W-1:0]                rs_tag
);

    // Stored-state lookup, optional commit forward, then x0 override.
    always_comb begin
        rs_value = reg_value[rs_addr];
        rs_busy  = reg_busy[rs_addr];
        rs_tag   = reg_tag[rs_addr];
`ifdef RF_COMMIT_BYPASS_EN
        if (rf_valid && rdy && (rf_rd == rs_addr) && (rs_addr != ZERO_REG) &&
            reg_busy[rs_addr] && (reg_tag[rs_addr] == rf_index)) begin
            rs_value = rf_value;
            rs_busy  = 1'b0;
        end
`endif
        if (rs_addr == ZERO_REG) begin
            rs_value = '0;
            rs_busy  = 1'b0;
            rs_tag   = '0;
        end
    end

endmodule

// File: rtl/register_file.sv
// Architectural register file with per-register rename tags.
// Commits from the ROB write values and retire busy bits; issues claim
// registers for an in-flight ROB entry; flush drops all claims.
// Optional macro RF_COMMIT_BYPASS_EN enables same-cycle commit forwarding.
module register_file
    import register_file_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rdy,
    input  logic                    issue_valid,
    input  logic [REG_IDX_W-1:0]    issue_rd,
    input  logic [ROB_IDX_W-1:0]    issue_rob_index,
    input  logic [REG_IDX_W-1:0]    rs1_addr,
    input  logic [REG_IDX_W-1:0]    rs2_addr,
    output logic [XLEN-1:0]         rs1_value,
    output logic                    rs1_busy,
    output logic [ROB_IDX_W-1:0]    rs1_tag,
    output logic [XLEN-1:0]         rs2_value,
    output logic                    rs2_busy,
    output logic [ROB_IDX_W-1:0]    rs2_tag,
    input  logic                    rf_valid,
    input  logic [ROB_IDX_W-1:0]    rf_index,
    input  logic [REG_IDX_W-1:0]    rf_rd,
    input  logic [XLEN-1:0]         rf_value,
    input  logic                    flush
);

    logic [REG_NUM-1:0][XLEN-1:0]      value_q, value_d;
    logic [REG_NUM-1:0]                busy_q,  busy_d;
    logic [REG_NUM-1:0][ROB_IDX_W-1:0] tag_q,   tag_d;

    // Next-state: commit first, then flush or issue (issue wins busy/tag).
    always_comb begin
        value_d = value_q;
        busy_d  = busy_q;
        tag_d   = tag_q;
        if (rdy) begin
            if (rf_valid && (rf_rd != ZERO_REG)) begin
                value_d[rf_rd] = rf_value;
                if (tag_q[rf_rd] == rf_index) begin
                    busy_d[rf_rd] = 1'b0;
                end
            end
            if (flush) begin
                busy_d = '0;
            end else if (issue_valid && (issue_rd != ZERO_REG)) begin
                busy_d[issue_rd] = 1'b1;
                tag_d[issue_rd]  = issue_rob_index;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= '0;
            busy_q  <= '0;
            tag_q   <= '0;
        end else begin
            value_q <= value_d;
            busy_q  <= busy_d;
            tag_q   <= tag_d;
        end
    end

    rf_read_port u_rs1_port (
        .rs_addr   (rs1_addr),
        .reg_value (value_q),
        .reg_busy  (busy_q),
        .reg_tag   (tag_q),
`ifdef RF_COMMIT_BYPASS_EN
        .rdy       (rdy),
        .rf_valid  (rf_valid),
        .rf_index  (rf_index),
        .rf_rd     (rf_rd),
        .rf_value  (rf_value),
`endif
        .rs_value  (rs1_value),
        .rs_busy   (rs1_busy),
        .rs_tag    (rs1_tag)
    );

    rf_read_port u_rs2_port (
        .rs_addr   (rs2_addr),
        .reg_value (value_q),
        .reg_busy  (busy_q),
        .reg_tag   (tag_q),
`ifdef RF_COMMIT_BYPASS_EN
        .rdy       (rdy),
        .rf_valid  (rf_valid),
        .rf_index  (rf_index),
        .rf_rd     (rf_rd),
        .rf_value  (rf_value),
`endif
        .rs_value  (rs2_value),
        .rs_busy   (rs2_busy),
        .rs_tag    (rs2_tag)
    );

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file.
module tb_register_file;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [5:0]  issue_rob_index;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_value;
    logic        rs1_busy;
    logic [5:0]  rs1_tag;
    logic [31:0] rs2_value;
    logic        rs2_busy;
    logic [5:0]  rs2_tag;
    logic        rf_valid;
    logic [5:0]  rf_index;
    logic [4:0]  rf_rd;
    logic [31:0] rf_value;
    logic        flush;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    register_file dut (
        .clk             (clk),
        .rst             (rst),
        .rdy             (rdy),
        .issue_valid     (issue_valid),
        .issue_rd        (issue_rd),
        .issue_rob_index (issue_rob_index),
        .rs1_addr        (rs1_addr),
        .rs2_addr        (rs2_addr),
        .rs1_value       (rs1_value),
        .rs1_busy        (rs1_busy),
        .rs1_tag         (rs1_tag),
        .rs2_value       (rs2_value),
        .rs2_busy        (rs2_busy),
        .rs2_tag         (rs2_tag),
        .rf_valid        (rf_valid),
        .rf_index        (rf_index),
        .rf_rd           (rf_rd),
        .rf_value        (rf_value),
        .flush           (flush)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        issue_valid = 1'b0; issue_rd = '0; issue_rob_index = '0;
        rf_valid = 1'b0; rf_index = '0; rf_rd = '0; rf_value = '0;
        flush = 1'b0;
    endtask

    // Clock one edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] rd, input logic [5:0] t);
        issue_valid = 1'b1; issue_rd = rd; issue_rob_index = t;
    endtask

    task automatic commit(input logic [4:0] rd, input logic [5:0] idx, input logic [31:0] v);
        rf_valid = 1'b1; rf_rd = rd; rf_index = idx; rf_value = v;
    endtask

    initial begin
        idle();
        rst = 1'b1; rdy = 1'b0; rs1_addr = 5'd1; rs2_addr = 5'd31;
        // 1. reset, with rdy low
        step();
        chk("rst_x1_val",  rs1_value, 32'h0);
        chk("rst_x1_busy", 32'(rs1_busy), 32'h0);
        chk("rst_x1_tag",  32'(rs1_tag), 32'h0);
        chk("rst_x31_val", rs2_value, 32'h0);
        chk("rst_x31_busy", 32'(rs2_busy), 32'h0);
        chk("rst_x31_tag", 32'(rs2_tag), 32'h0);
        rst = 1'b0; rdy = 1'b1;

        // 2. issue x5 tag 3, then commit it
        issue(5'd5, 6'd3);
        step(); idle();
        rs1_addr = 5'd5; #1;
        chk("x5_busy_after_issue", 32'(rs1_busy), 32'h1);
        chk("x5_tag_after_issue",  32'(rs1_tag), 32'd3);
        commit(5'd5, 6'd3, 32'hDEADBEEF); #1;
`ifdef RF_COMMIT_BYPASS_EN
        chk("x5_bypass_busy", 32'(rs1_busy), 32'h0);
        chk("x5_bypass_val",  rs1_value, 32'hDEADBEEF);
`else
        chk("x5_nobypass_busy", 32'(rs1_busy), 32'h1);
        chk("x5_nobypass_val",  rs1_value, 32'h0);
`endif
        step(); idle(); #1;
        chk("x5_busy_after_commit", 32'(rs1_busy), 32'h0);
        chk("x5_val_after_commit",  rs1_value, 32'hDEADBEEF);

        // 3. two producers of x7; older commit must not clear busy
        issue(5'd7, 6'd1); step();
        issue(5'd7, 6'd2); step(); idle();
        commit(5'd7, 6'd1, 32'h11); rs2_addr = 5'd7; #1;
        chk("x7_stale_commit_no_fwd", 32'(rs2_busy), 32'h1);
        step(); idle(); #1;
        chk("x7_val_stale",  rs2_value, 32'h11);
        chk("x7_busy_stale", 32'(rs2_busy), 32'h1);
        chk("x7_tag_stale",  32'(rs2_tag), 32'd2);
        commit(5'd7, 6'd2, 32'h22); step(); idle(); #1;
        chk("x7_busy_final", 32'(rs2_busy), 32'h0);
        chk("x7_val_final",  rs2_value, 32'h22);

        // 4. same-cycle commit and issue to x9
        commit(5'd9, 6'd4, 32'h55); issue(5'd9, 6'd8);
        step(); idle();
        rs1_addr = 5'd9; #1;
        chk("x9_val",  rs1_value, 32'h55);
        chk("x9_busy", 32'(rs1_busy), 32'h1);
        chk("x9_tag",  32'(rs1_tag), 32'd8);

        // 5. flush with concurrent commit and issue
        issue(5'd1, 6'd10); step();
        issue(5'd2, 6'd11); step();
        issue(5'd3, 6'd12); step(); idle();
        rs1_addr = 5'd2; #1;
        chk("x2_busy_pre_flush", 32'(rs1_busy), 32'h1);
        chk("x2_tag_pre_flush",  32'(rs1_tag), 32'd11);
        flush = 1'b1; commit(5'd4, 6'd20, 32'h99); issue(5'd6, 6'd13);
        step(); idle();
        rs1_addr = 5'd1; rs2_addr = 5'd3; #1;
        chk("x1_busy_flushed", 32'(rs1_busy), 32'h0);
        chk("x3_busy_flushed", 32'(rs2_busy), 32'h0);
        rs1_addr = 5'd4; rs2_addr = 5'd6; #1;
        chk("x4_val_flush_commit", rs1_value, 32'h99);
        chk("x6_not_busy",         32'(rs2_busy), 32'h0);
        rs1_addr = 5'd9; #1;
        chk("x9_busy_flushed", 32'(rs1_busy), 32'h0);

        // 6. x0 writes discarded; rdy low freezes state
        commit(5'd0, 6'd0, 32'h1234); issue(5'd0, 6'd5);
        step(); idle();
        rs1_addr = 5'd0; #1;
        chk("x0_val",  rs1_value, 32'h0);
        chk("x0_busy", 32'(rs1_busy), 32'h0);
        chk("x0_tag",  32'(rs1_tag), 32'h0);
        rdy = 1'b0;
        issue(5'd10, 6'd7); commit(5'd5, 6'd0, 32'hCAFE);
        step(); idle(); rdy = 1'b1;
        rs1_addr = 5'd10; rs2_addr = 5'd5; #1;
        chk("x10_busy_rdy_low", 32'(rs1_busy), 32'h0);
        chk("x5_val_rdy_low",   rs2_value, 32'hDEADBEEF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
